// File: rtl/audio_stream_pkg.sv
// Shared constants for the audio stream scheduler: silence byte, FSM encoding,
// and the sample-rate divider calculation.
package audio_stream_pkg;

   localparam logic [7:0] SILENCE_BYTE = 8'h80;

   localparam int unsigned STATE_W = 2;
   localparam logic [STATE_W-1:0] ST_IDLE    = 2'd0;
   localparam logic [STATE_W-1:0] ST_PREFILL = 2'd1;
   localparam logic [STATE_W-1:0] ST_PLAY    = 2'd2;

   // Clock cycles per output sample; returns 0 when the ratio is below 4 (unusable).
   function automatic int unsigned calc_div(input int unsigned clk_hz,
                                            input int unsigned sample_hz);
      int unsigned div;
      div = (sample_hz == 0) ? 0 : clk_hz / sample_hz;
      return (div < 4) ? 0 : div;
   endfunction

endpackage

// File: rtl/sync_byte_fifo.sv
// Single-clock byte FIFO with synchronous flush; head byte is visible
// combinationally on rd_data, level is registered.
module sync_byte_fifo #(
   parameter int unsigned DEPTH = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     wr_en,
   input  logic [7:0]               wr_data,
   input  logic                     rd_en,
   output logic [7:0]               rd_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          wr_ok;
   logic          rd_ok;

   assign full    = (level == LW'(DEPTH));
   assign empty   = (level == '0);
   assign rd_data = mem[rd_ptr];

   // A write into a full FIFO is allowed when the head leaves in the same cycle.
   assign rd_ok = rd_en && !empty && !flush;
   assign wr_ok = wr_en && !flush && (!full || rd_ok);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
         if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
         if (wr_ok && !rd_ok)      level <= level + LW'(1);
         else if (!wr_ok && rd_ok) level <= level - LW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/audio_stream_scheduler.sv
// Paces buffered UART audio bytes into the DSP stage at a fixed sample rate,
// substituting mid-scale silence whenever no byte is available.
// Optional statistics counters are built when AUDIO_SCHED_STATS_EN is defined.
module audio_stream_scheduler
   import audio_stream_pkg::*;
#(
   parameter int unsigned CLK_HZ    = 27000000,
   parameter int unsigned SAMPLE_HZ = 8000,
   parameter int unsigned DEPTH     = 64,
   parameter int unsigned PREFILL   = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [7:0]                rx_data,
   input  logic                      rx_valid,
   input  logic                      enable,
   output logic [7:0]                dsp_data,
   output logic                      dsp_byte_ready,
   output logic [$clog2(DEPTH):0]    fifo_level,
   output logic                      playing,
   output logic                      underrun,
   output logic                      overflow
`ifdef AUDIO_SCHED_STATS_EN
   ,
   output logic [15:0]               underrun_cnt,
   output logic [15:0]               overflow_cnt
`endif
);

   localparam int unsigned DIV   = calc_div(CLK_HZ, SAMPLE_HZ);
   localparam int unsigned DIV_W = (DIV < 4) ? 2 : $clog2(DIV);
   localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

   if (DIV == 0) begin : g_bad_div
      $error("audio_stream_scheduler: CLK_HZ/SAMPLE_HZ must be at least 4");
   end
   if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("audio_stream_scheduler: DEPTH must be a power of two >= 4");
   end
   if ((PREFILL < 1) || (PREFILL > DEPTH)) begin : g_bad_prefill
      $error("audio_stream_scheduler: PREFILL must be within 1..DEPTH");
   end

   logic [DIV_W-1:0]   div_cnt;
   logic               tick_c;
   logic [STATE_W-1:0] state_q;
   logic [STATE_W-1:0] state_d;
   logic [7:0]         dsp_data_d;
   logic               strobe_d;
   logic               underrun_d;
   logic               overflow_d;
   logic               pop;
   logic               wr_en;
   logic               flush;
   logic [7:0]         fifo_rd_data;
   logic               fifo_full;
   logic               fifo_empty;

   // Free-running sample divider, independent of FSM state.
   assign tick_c = (div_cnt == DIV_W'(DIV - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      div_cnt <= '0;
      else if (tick_c) div_cnt <= '0;
      else             div_cnt <= div_cnt + DIV_W'(1);
   end

   sync_byte_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (flush),
      .wr_en   (wr_en),
      .wr_data (rx_data),
      .rd_en   (pop),
      .rd_data (fifo_rd_data),
      .level   (fifo_level),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Next-state and next-output logic; every tick schedules silence unless PLAY pops a byte.
   always_comb begin
      state_d    = state_q;
      dsp_data_d = dsp_data;
      strobe_d   = 1'b0;
      underrun_d = 1'b0;
      overflow_d = 1'b0;
      pop        = 1'b0;
      wr_en      = 1'b0;
      flush      = 1'b0;

      if (tick_c) begin
         strobe_d   = 1'b1;
         dsp_data_d = SILENCE_BYTE;
      end

      case (state_q)
         ST_IDLE: begin
            flush = 1'b1;
            if (enable) state_d = ST_PREFILL;
         end
         ST_PREFILL: begin
            if (!enable) begin
               flush   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               wr_en = rx_valid;
               if (fifo_level >= LVL_W'(PREFILL)) state_d = ST_PLAY;
            end
         end
         ST_PLAY: begin
            // Dropping enable flushes on the same edge that enters IDLE.
            if (!enable) begin
               flush   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               wr_en = rx_valid;
               if (tick_c) begin
                  if (fifo_empty) begin
                     underrun_d = 1'b1;
                     state_d    = ST_PREFILL;
                  end else begin
                     pop        = 1'b1;
                     dsp_data_d = fifo_rd_data;
                  end
               end
            end
         end
         default: begin
            flush   = 1'b1;
            state_d = ST_IDLE;
         end
      endcase

      overflow_d = wr_en && fifo_full && !pop;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         dsp_data       <= SILENCE_BYTE;
         dsp_byte_ready <= 1'b0;
         underrun       <= 1'b0;
         overflow       <= 1'b0;
         playing        <= 1'b0;
      end else begin
         state_q        <= state_d;
         dsp_data       <= dsp_data_d;
         dsp_byte_ready <= strobe_d;
         underrun       <= underrun_d;
         overflow       <= overflow_d;
         playing        <= (state_d == ST_PLAY);
      end
   end

`ifdef AUDIO_SCHED_STATS_EN
   // Saturating event counters, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         underrun_cnt <= '0;
         overflow_cnt <= '0;
      end else begin
         if (underrun_d && (underrun_cnt != 16'hFFFF)) underrun_cnt <= underrun_cnt + 16'd1;
         if (overflow_d && (overflow_cnt != 16'hFFFF)) overflow_cnt <= overflow_cnt + 16'd1;
      end
   end
`else
   // Statistics counters not built in this configuration.
`endif

endmodule

// File: tb/tb_audio_stream_scheduler.sv
// Directed bench for audio_stream_scheduler with DIV=10, DEPTH=8, PREFILL=4.
module tb_audio_stream_scheduler;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0;
   logic       enable = 1'b0;
   logic [7:0] dsp_data;
   logic       dsp_byte_ready;
   logic [3:0] fifo_level;
   logic       playing;
   logic       underrun;
   logic       overflow;
`ifdef AUDIO_SCHED_STATS_EN
   logic [15:0] underrun_cnt;
   logic [15:0] overflow_cnt;
`endif

   int checks = 0;
   int failures = 0;

   audio_stream_scheduler #(
      .CLK_HZ    (1000),
      .SAMPLE_HZ (100),
      .DEPTH     (8),
      .PREFILL   (4)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .rx_data        (rx_data),
      .rx_valid       (rx_valid),
      .enable         (enable),
      .dsp_data       (dsp_data),
      .dsp_byte_ready (dsp_byte_ready),
      .fifo_level     (fifo_level),
      .playing        (playing),
      .underrun       (underrun),
      .overflow       (overflow)
`ifdef AUDIO_SCHED_STATS_EN
      ,
      .underrun_cnt   (underrun_cnt),
      .overflow_cnt   (overflow_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_strobe(input string tag, output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (dsp_byte_ready !== 1'b1 && n < 25);
      chk({tag, "_strobe"}, 32'(dsp_byte_ready), 32'd1);
   endtask

   task automatic write_byte(input logic [7:0] d);
      rx_data  = d;
      rx_valid = 1'b1;
      step();
      rx_valid = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_data"},     32'(dsp_data),       32'h80);
      chk({tag, "_ready"},    32'(dsp_byte_ready), 32'd0);
      chk({tag, "_level"},    32'(fifo_level),     32'd0);
      chk({tag, "_playing"},  32'(playing),        32'd0);
      chk({tag, "_underrun"}, 32'(underrun),       32'd0);
      chk({tag, "_overflow"}, 32'(overflow),       32'd0);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [7:0] pops [4];
      pops[0] = 8'h10; pops[1] = 8'h20; pops[2] = 8'h30; pops[3] = 8'h40;

      #12;
      chk_reset_vals("rst");
      #10 rst_n = 1'b1;

      // IDLE: strobes every DIV cycles with silence, rx traffic discarded.
      rx_data  = 8'h55;
      rx_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         n = 0;
         do begin
            step();
            n++;
            chk("idle_level", 32'(fifo_level), 32'd0);
            chk("idle_ovf", 32'(overflow), 32'd0);
         end while (dsp_byte_ready !== 1'b1 && n < 25);
         chk("idle_gap", 32'(n), 32'd10);
         chk("idle_data", 32'(dsp_data), 32'h80);
         chk("idle_playing", 32'(playing), 32'd0);
      end
      rx_valid = 1'b0;

      // Prefill four bytes, then play them back in order and underrun.
      enable = 1'b1;
      step();
      chk("strobe_one_cycle", 32'(dsp_byte_ready), 32'd0);
      write_byte(8'h10);
      write_byte(8'h20);
      write_byte(8'h30);
      write_byte(8'h40);
      chk("prefill_level", 32'(fifo_level), 32'd4);
      chk("prefill_not_playing", 32'(playing), 32'd0);
      step();
      chk("play_rise", 32'(playing), 32'd1);
      for (int k = 0; k < 4; k++) begin
         wait_strobe("play", n);
         chk("play_data", 32'(dsp_data), 32'(pops[k]));
         chk("play_underrun", 32'(underrun), 32'd0);
         chk("play_level", 32'(fifo_level), 32'(3 - k));
      end
      wait_strobe("under", n);
      chk("under_data", 32'(dsp_data), 32'h80);
      chk("under_pulse", 32'(underrun), 32'd1);
      chk("under_playing", 32'(playing), 32'd0);
      step();
      chk("under_one_cycle", 32'(underrun), 32'd0);

      // Fill to DEPTH, then two dropped bytes while no tick is due.
      for (int k = 1; k <= 8; k++) write_byte(8'hA0 + 8'(k));
      chk("fill_level", 32'(fifo_level), 32'd8);
      chk("fill_playing", 32'(playing), 32'd1);
      wait_strobe("fill_pop", n);
      chk("fill_pop_data", 32'(dsp_data), 32'hA1);
      chk("fill_pop_level", 32'(fifo_level), 32'd7);
      write_byte(8'hA9);
      chk("refill_level", 32'(fifo_level), 32'd8);
      chk("refill_ovf", 32'(overflow), 32'd0);
      write_byte(8'hEE);
      chk("ovf1", 32'(overflow), 32'd1);
      chk("ovf1_level", 32'(fifo_level), 32'd8);
      write_byte(8'hEF);
      chk("ovf2", 32'(overflow), 32'd1);
      chk("ovf2_level", 32'(fifo_level), 32'd8);
      step();
      chk("ovf_clear", 32'(overflow), 32'd0);

      // Write coinciding with a tick pop at full level.
      repeat (5) step();
      write_byte(8'hB0);
      chk("coinc_strobe", 32'(dsp_byte_ready), 32'd1);
      chk("coinc_data", 32'(dsp_data), 32'hA2);
      chk("coinc_level", 32'(fifo_level), 32'd8);
      chk("coinc_ovf", 32'(overflow), 32'd0);
      for (int k = 3; k <= 5; k++) begin
         wait_strobe("drain", n);
         chk("drain_data", 32'(dsp_data), 32'hA0 + 32'(k));
         chk("drain_level", 32'(fifo_level), 32'(10 - k));
      end

      // Drop enable mid-PLAY at level 5.
      enable = 1'b0;
      step();
      chk("disable_playing", 32'(playing), 32'd0);
      chk("disable_level", 32'(fifo_level), 32'd0);
      wait_strobe("disable_s1", n);
      chk("disable_s1_data", 32'(dsp_data), 32'h80);
      chk("disable_s1_underrun", 32'(underrun), 32'd0);
      wait_strobe("disable_s2", n);
      chk("disable_s2_data", 32'(dsp_data), 32'h80);
`ifdef AUDIO_SCHED_STATS_EN
      chk("stat_underrun", 32'(underrun_cnt), 32'd1);
      chk("stat_overflow", 32'(overflow_cnt), 32'd2);
`endif

      // Asynchronous reset while playing.
      enable = 1'b1;
      step();
      write_byte(8'hC1);
      write_byte(8'hC2);
      write_byte(8'hC3);
      write_byte(8'hC4);
      step();
      chk("replay_playing", 32'(playing), 32'd1);
      wait_strobe("replay", n);
      chk("replay_data", 32'(dsp_data), 32'hC1);
      #2 rst_n = 1'b0;
      #1;
      chk_reset_vals("async_rst");
      #3 rst_n = 1'b1;
      step();
      chk("post_rst_data", 32'(dsp_data), 32'h80);
      chk("post_rst_level", 32'(fifo_level), 32'd0);
      chk("post_rst_playing", 32'(playing), 32'd0);
`ifdef AUDIO_SCHED_STATS_EN
      chk("post_rst_ucnt", 32'(underrun_cnt), 32'd0);
      chk("post_rst_ocnt", 32'(overflow_cnt), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/audio_stream_scheduler.md
Name: audio_stream_scheduler

Overview:
- Sits between the UART byte receiver and the DSP filter/dither stage.
- Buffers incoming audio bytes in a small FIFO and waits for a prefill level before playback starts.
- Drives the DSP byte strobe at a fixed audio sample rate derived from the system clock.
- On underrun it feeds mid-scale silence, so the DSP FIR history and I2S cadence never stall.

Parameters:
- CLK_HZ, 27000000, system clock frequency.
- SAMPLE_HZ, 8000, output sample rate; DIV = CLK_HZ/SAMPLE_HZ (integer truncation, must be >= 4).
- DEPTH, 64, FIFO depth in bytes; power of two, >= 4.
- PREFILL, 32, fill level required to enter PLAY; 1 <= PREFILL <= DEPTH.

Ports:
- clk  in  1  system clock; all logic is single-clock.
- rst_n  in  1  asynchronous, active-low reset.
- rx_data  in  8  received byte, unsigned 8-bit PCM.
- rx_valid  in  1  one-cycle strobe qualifying rx_data.
- enable  in  1  playback enable (level).
- dsp_data  out  8  byte presented to the DSP stage.
- dsp_byte_ready  out  1  one-cycle strobe qualifying dsp_data.
- fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- playing  out  1  high while state == PLAY.
- underrun  out  1  one-cycle pulse on underrun.
- overflow  out  1  one-cycle pulse when a byte is dropped because the FIFO is full.

Behaviour:
- Reset (async assert, sync release): state IDLE, divider 0, FIFO empty, dsp_data = 8'h80, all other outputs 0.
- Sample tick:
  - Free-running divider counts 0..DIV-1; tick is asserted in the cycle the count equals DIV-1, then the count wraps to 0.
  - The divider runs in every state.
- FIFO:
  - Write when rx_valid and (not full, or a read in the same cycle).
  - Full with no read: byte dropped, overflow pulses the next cycle.
  - A byte written in cycle t is readable from t+1.
  - fifo_level is registered and reflects the prior cycle's write/read.
- Output strobe: every tick produces exactly one dsp_byte_ready pulse in the cycle after the tick; dsp_data updates in that same cycle.
- States:
  - IDLE (enable=0): FIFO flushed every cycle, rx bytes discarded with no overflow pulse; tick emits 8'h80. enable=1 -> PREFILL.
  - PREFILL: FIFO accepts bytes; tick emits 8'h80. When fifo_level >= PREFILL -> PLAY on the next edge. enable=0 -> IDLE.
  - PLAY, tick with fifo_level > 0: pop head, emit it.
  - PLAY, tick with fifo_level == 0: emit 8'h80, pulse underrun alongside the strobe, go to PREFILL.
  - PLAY, enable=0: go to IDLE next edge and flush; any strobe already scheduled still fires, with 8'h80.
- Simultaneous events:
  - Tick pop and rx write in the same cycle: both occur, level unchanged.
  - Tick coincides with reaching PREFILL: the strobe carries 8'h80, and the first real byte goes out on the next tick.
- Reset mid-operation: immediate return to reset values; any pending strobe is lost.

Optional Feature:
- AUDIO_SCHED_STATS_EN defined:
  - Adds outputs underrun_cnt[15:0] and overflow_cnt[15:0].
  - Each counter increments on its pulse and saturates at 16'hFFFF.
  - Counters clear on reset only; enable does not clear them.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package audio_stream_pkg holds:
  - SILENCE_BYTE = 8'h80.
  - State encoding IDLE/PREFILL/PLAY (2-bit).
  - A constant function computing DIV and checking DIV >= 4.
- Sub-module sync_byte_fifo holds the FIFO:
  - Parameter DEPTH; ports clk, rst_n, flush, wr_en, wr_data, rd_en, rd_data, level, full, empty.
  - rd_data is valid combinationally at the head.
- The scheduler contains the divider, the FSM and output registers.

Test Plan (CLK_HZ=1000, SAMPLE_HZ=100 -> DIV=10, DEPTH=8, PREFILL=4):
- Reset, then enable=0 for 50 cycles -> dsp_byte_ready pulses every 10 cycles with dsp_data=8'h80; playing=0; fifo_level=0.
- enable=1, write 8'h10,8'h20,8'h30,8'h40 -> playing rises the cycle after level=4; next ticks emit 10,20,30,40 in order, then the fifth tick gives 8'h80, underrun=1, state PREFILL.
- Fill to 8, then 2 more rx_valid with no tick in between -> two overflow pulses; level stays 8; dropped bytes never appear on dsp_data.
- In PLAY at level 8, rx_valid in the same cycle as a tick pop -> byte accepted, level stays 8, no overflow.
- Drop enable mid-PLAY with level 5 -> next cycle playing=0, level 0; subsequent strobes carry 8'h80.
- Assert rst_n=0 asynchronously between clock edges during PLAY -> all outputs return to reset values immediately; with AUDIO_SCHED_STATS_EN, counters read 0 after release.
